// File: rtl/pixel_state_if.sv
// pixel_state_if: byte stream carrying the pixel readout (AXI4-Stream subset).
//   valid  : byte valid (tvalid), driven by the master
//   ready  : consumer ready (tready), driven by the slave
//   tlast  : last byte of the frame
//   tdata  : pixel byte
interface pixel_state_if;
  logic       valid;
  logic       ready;
  logic       tlast;
  logic [7:0] tdata;

  modport master (output valid, output tlast, output tdata, input ready);
  modport slave  (input valid, input tlast, input tdata, output ready);
endinterface

// File: rtl/pixel_state.sv
// pixel_state: frame-sequencing controller for one pixel-array capture.
// A trigger in IDLE runs ERASE -> EXPOSE -> CONVERT for fixed cycle counts,
// then READOUT streams NUM_PIXELS bytes on the master stream interface.
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   trigger : capture request, level, honoured only in IDLE
//   axis    : stream master (valid/tlast/tdata out, ready in), all outputs registered
module pixel_state #(
  parameter int unsigned ERASE_CYCLES   = 5,
  parameter int unsigned EXPOSE_CYCLES  = 255,
  parameter int unsigned CONVERT_CYCLES = 256,
  parameter int unsigned NUM_PIXELS     = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           trigger,
  pixel_state_if.master  axis
);

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    READOUT
  } state_e;

  localparam logic [15:0] ERASE_LAST   = 16'(ERASE_CYCLES - 1);
  localparam logic [15:0] EXPOSE_LAST  = 16'(EXPOSE_CYCLES - 1);
  localparam logic [15:0] CONVERT_LAST = 16'(CONVERT_CYCLES - 1);
  localparam logic [7:0]  PIX_LAST     = 8'(NUM_PIXELS - 1);

  state_e      state_q;
  logic [15:0] phase_q;
  logic [7:0]  pix_q;
  logic [7:0]  frame_q;
  logic        valid_q;
  logic        tlast_q;
  logic [7:0]  tdata_q;
  logic [7:0]  frame_base;

  // First byte of the frame; later bytes are produced by incrementing tdata_q,
  // which equals frame*NUM_PIXELS + pixel modulo 256.
  assign frame_base = 8'(32'(frame_q) * NUM_PIXELS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      pix_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      tlast_q <= 1'b0;
      tdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_q <= ERASE;
            phase_q <= '0;
          end
        end
        ERASE: begin
          if (phase_q == ERASE_LAST) begin
            state_q <= EXPOSE;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + 16'd1;
          end
        end
        EXPOSE: begin
          if (phase_q == EXPOSE_LAST) begin
            state_q <= CONVERT;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + 16'd1;
          end
        end
        CONVERT: begin
          if (phase_q == CONVERT_LAST) begin
            // Present the first beat on the same edge READOUT is entered so
            // valid is registered yet visible from the first READOUT cycle.
            state_q <= READOUT;
            phase_q <= '0;
            pix_q   <= '0;
            valid_q <= 1'b1;
            tdata_q <= frame_base;
            tlast_q <= (PIX_LAST == 8'd0);
          end else begin
            phase_q <= phase_q + 16'd1;
          end
        end
        READOUT: begin
          // valid_q is always 1 here, so ready alone marks a transfer.
          if (axis.ready) begin
            if (tlast_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              tlast_q <= 1'b0;
              frame_q <= frame_q + 8'd1;
            end else begin
              pix_q   <= pix_q + 8'd1;
              tdata_q <= tdata_q + 8'd1;
              tlast_q <= ((pix_q + 8'd1) == PIX_LAST);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign axis.valid = valid_q;
  assign axis.tlast = tlast_q;
  assign axis.tdata = tdata_q;

endmodule

// File: tb/tb_pixel_state.sv
module tb_pixel_state;

  localparam int unsigned NPIX = 4;

  logic clk;
  logic rst;
  logic trigger;
  int   passed;
  int   total;

  pixel_state_if axis ();

  pixel_state #(
    .ERASE_CYCLES   (5),
    .EXPOSE_CYCLES  (255),
    .CONVERT_CYCLES (256),
    .NUM_PIXELS     (NPIX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .trigger (trigger),
    .axis    (axis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Watch 'cycles' clocks and require valid to stay low throughout.
  task automatic expect_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      seen = seen | axis.valid;
    end
    check(tag, {7'd0, seen}, 8'd0);
  endtask

  // Pulse trigger, verify the 516-cycle latency, then consume 'beats' bytes.
  // alt: ready high on the first valid cycle, then alternating.
  // busy: extra trigger pulses during EXPOSE and during READOUT.
  task automatic run_frame(input logic [7:0] base, input bit alt, input bit busy,
                           input int beats);
    int i;
    int cyc;
    logic [7:0] exp_d;
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);          // trigger sampled at edge T
    trigger = 1'b0;
    for (int k = 1; k <= 515; k++) begin
      trigger = (busy && k == 100);
      @(negedge clk);
    end
    trigger = 1'b0;
    check("latency_pre", {7'd0, axis.valid}, 8'd0);
    @(negedge clk);          // after edge T+516
    i   = 0;
    cyc = 0;
    while (i < beats && cyc < 40) begin
      axis.ready = alt ? (cyc % 2 == 0) : 1'b1;
      trigger    = (busy && cyc == 1);
      exp_d      = base + 8'(i);
      check("beat_valid", {7'd0, axis.valid}, 8'd1);
      check("beat_tdata", axis.tdata, exp_d);
      check("beat_tlast", {7'd0, axis.tlast}, {7'd0, (i == NPIX - 1)});
      if (axis.ready) i++;
      cyc++;
      @(negedge clk);
    end
    trigger    = 1'b0;
    axis.ready = 1'b1;
    check("beats_done", 8'(i), 8'(beats));
    if (beats == NPIX) begin
      check("end_valid", {7'd0, axis.valid}, 8'd0);
      check("end_tlast", {7'd0, axis.tlast}, 8'd0);
      check("end_tdata_hold", axis.tdata, base + 8'(NPIX - 1));
    end
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst        = 1'b0;
    trigger    = 1'b0;
    axis.ready = 1'b1;

    // Reset held with trigger toggling
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      trigger = ~trigger;
      check("rst_valid", {7'd0, axis.valid}, 8'd0);
      check("rst_tlast", {7'd0, axis.tlast}, 8'd0);
      check("rst_tdata", axis.tdata, 8'd0);
    end
    trigger = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expect_quiet("idle_after_reset", 600);

    // Frame 0, ready high
    run_frame(8'd0, 1'b0, 1'b0, NPIX);
    // Frame 1, alternating ready
    run_frame(8'd4, 1'b1, 1'b0, NPIX);
    // Frame 2, trigger pulses while busy must not queue a frame
    run_frame(8'd8, 1'b0, 1'b1, NPIX);
    expect_quiet("no_extra_frame", 600);

    // Frame 3 aborted by reset after two beats
    run_frame(8'd12, 1'b0, 1'b0, 2);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", {7'd0, axis.valid}, 8'd0);
    check("async_rst_tlast", {7'd0, axis.tlast}, 8'd0);
    check("async_rst_tdata", axis.tdata, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Frame counter cleared by reset; then walk up to the mod-256 wrap
    run_frame(8'd0, 1'b0, 1'b0, NPIX);
    for (int f = 1; f < 64; f++) begin
      run_frame(8'(f * 4), 1'b0, 1'b0, NPIX);
    end
    run_frame(8'd0, 1'b1, 1'b0, NPIX);   // frame 64: 64*4 mod 256 = 0

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pixel_state.md
Name: pixel_state

Overview:
- Frame-sequencing controller for one pixel-array capture. A trigger starts a fixed sequence: ERASE, EXPOSE, CONVERT, then READOUT.
- READOUT streams one byte per pixel on an AXI4-Stream-style master interface (valid/ready/tlast/tdata).
- Sits between the capture trigger source and the downstream stream consumer (DMA/packetizer).

Parameters:
- ERASE_CYCLES, 5, clock cycles spent in ERASE (>=1)
- EXPOSE_CYCLES, 255, clock cycles spent in EXPOSE (>=1)
- CONVERT_CYCLES, 256, clock cycles spent in CONVERT (>=1)
- NUM_PIXELS, 4, bytes streamed per frame (1..256)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted); one clock, reset is asynchronous and active-low
- trigger  in  1  capture request, level, sampled on clk
- ready  in  1  downstream ready (AXIS tready)
- valid  out  1  output byte valid (AXIS tvalid)
- tlast  out  1  last byte of frame (AXIS tlast)
- tdata  out  8  pixel byte (AXIS tdata)

Behaviour:
- State encoding:
  - IDLE, ERASE, EXPOSE, CONVERT, READOUT.
  - A phase cycle counter (>=9 bits).
  - Pixel index (8 bits).
  - Frame counter (8 bits).
- Reset (rst=0, asynchronous, any state):
  - State returns to IDLE; all counters are cleared.
  - valid=0, tlast=0, tdata=0 immediately.
  - Reset mid-frame aborts the frame; no partial tlast is emitted.
- IDLE:
  - valid=0.
  - trigger=1 at a rising edge moves to ERASE on that edge; phase counter loads 0.
- ERASE / EXPOSE / CONVERT:
  - Each lasts exactly its parameter count of cycles, then advances to the next state.
  - Leaving CONVERT enters READOUT with pixel index 0.
- Trigger rules:
  - trigger is ignored in every state except IDLE (no queuing).
  - Holding trigger high continuously re-arms the next frame as soon as IDLE is re-entered.
- READOUT output:
  - valid=1 from the first READOUT cycle.
  - tdata = (frame_count*NUM_PIXELS + pixel_index) mod 256.
  - tlast=1 only while pixel_index == NUM_PIXELS-1.
- READOUT handshake:
  - A transfer occurs on a rising edge with valid=1 and ready=1; pixel index then increments.
  - While valid=1 and ready=0, tdata/tlast/valid hold stable (AXIS rule); there is no combinational path from ready to valid.
- Frame end:
  - The transfer with tlast=1 ends the frame.
  - Next cycle: state IDLE, valid=0, tlast=0, frame_count increments (wraps 255->0).
- Outputs are registered. tdata holds its last value in non-READOUT states except after reset (0).
- Latency:
  - Trigger sampled at edge T gives the first valid at edge T+ERASE_CYCLES+EXPOSE_CYCLES+CONVERT_CYCLES.
  - Default: 516 cycles after the trigger edge.
- Throughput:
  - With ready tied high, one byte per cycle; a frame takes NUM_PIXELS cycles.
  - With ready alternating, every stalled beat is held, never dropped or duplicated.

Test Plan:
- Reset hold: rst=0 for 2 cycles with trigger toggling -> valid=0, tlast=0, tdata=0 throughout; state stays IDLE after release until trigger.
- Single frame, ready=1: trigger=1 for 1 cycle -> valid rises 516 cycles later; tdata=0,1,2,3 on consecutive cycles; tlast only with 3; valid=0 the next cycle.
- Backpressure: downstream drops ready the cycle after valid and raises it again the following cycle (ready alternates) -> each byte 0..3 accepted exactly once; tdata/tlast stable while ready=0.
- Second frame: trigger again after IDLE -> tdata=4,5,6,7, tlast on 7. With NUM_PIXELS=4, frame 64 yields tdata 0..3 (mod-256 wrap).
- Trigger while busy: pulse trigger during EXPOSE and during READOUT -> no extra frame; exactly 4 beats emitted.
- Reset mid-READOUT: assert rst after 2 beats -> valid/tlast drop asynchronously; the next trigger gives a frame starting at tdata=0 (frame counter cleared).
